// File: rtl/stdp_ctrl_if.sv
// Signal bundle between the STDP learning controller and the neuron pair /
// configuration logic around it. Clock and reset stay plain ports on the
// block itself.
interface stdp_ctrl_if;
  logic       en;
  logic       pre_spike;
  logic       post_spike;
  logic       wload;
  logic [7:0] wdata;
  logic [7:0] weight;
  logic [7:0] syn_current;
  logic       update_pulse;
  logic       ltp;
  logic       ltd;
  logic [4:0] dt_out;

  // Environment side: drives spikes, enable and weight loads.
  modport master (
    output en, pre_spike, post_spike, wload, wdata,
    input  weight, syn_current, update_pulse, ltp, ltd, dt_out
  );

  // Controller side.
  modport slave (
    input  en, pre_spike, post_spike, wload, wdata,
    output weight, syn_current, update_pulse, ltp, ltd, dt_out
  );
endinterface

// File: rtl/stdp_ctrl.sv
// STDP learning controller for a two-neuron LIF pair.
// Each spike restarts its own 5-bit saturating timer; a spike arriving while
// the partner timer is live (1..WIN) forms a pairing and moves the 8-bit
// weight by a stepped delta (16/8/4/2 by interval). Post-after-pre
// potentiates, pre-after-post depresses, and either way the partner timer is
// cleared so a pairing is used once. The presynaptic spike is also gated
// into a one-cycle current pulse equal to the weight it saw.
module stdp_ctrl #(
  parameter logic [7:0]  W_INIT = 8'd16,
  parameter int unsigned WIN    = 15      // legal 1..30
) (
  input logic         clk,
  input logic         rst_n,
  stdp_ctrl_if.slave  bus
);

  localparam logic [4:0] WIN_T   = 5'(WIN);
  localparam logic [4:0] T_EXPIRED = 5'(WIN + 1);

  logic [4:0] pre_t;
  logic [4:0] post_t;

  logic       pre_live;
  logic       post_live;
  logic       ltp_hit;
  logic       ltd_hit;
  logic [8:0] sum9;
  logic [8:0] diff9;
  logic [7:0] w_up;
  logic [7:0] w_down;
  logic [4:0] pre_t_nxt;
  logic [4:0] post_t_nxt;

  // Stepped learning rate: closer spike pairs move the weight further.
  function automatic logic [7:0] delta(input logic [4:0] dt);
    if (dt <= 5'd2)      return 8'd16;
    else if (dt <= 5'd4) return 8'd8;
    else if (dt <= 5'd8) return 8'd4;
    else                 return 8'd2;
  endfunction

  // A running timer counts up to the expired marker and parks there;
  // an idle (zero) timer stays idle.
  function automatic logic [4:0] tick(input logic [4:0] t);
    if (t != 5'd0 && t < T_EXPIRED) return t + 5'd1;
    else                            return t;
  endfunction

  // Pairing detection, saturating weight arithmetic and timer next-state.
  always_comb begin
    // NOTE: every signal gets a value on every path here, so no latch is inferred.
    pre_live   = (pre_t  != 5'd0) && (pre_t  <= WIN_T);
    post_live  = (post_t != 5'd0) && (post_t <= WIN_T);
    ltp_hit    = bus.post_spike && !bus.pre_spike && pre_live;
    ltd_hit    = bus.pre_spike && !bus.post_spike && post_live;

    sum9       = {1'b0, bus.weight} + {1'b0, delta(pre_t)};
    diff9      = {1'b0, bus.weight} - {1'b0, delta(post_t)};
    w_up       = sum9[8]  ? 8'd255 : sum9[7:0];
    w_down     = diff9[8] ? 8'd0   : diff9[7:0];

    // Own spike restarts the timer; a pairing consumes the partner's timer.
    pre_t_nxt  = tick(pre_t);
    post_t_nxt = tick(post_t);
    if (bus.pre_spike)   pre_t_nxt  = 5'd1;
    else if (ltp_hit)    pre_t_nxt  = 5'd0;
    if (bus.post_spike)  post_t_nxt = 5'd1;
    else if (ltd_hit)    post_t_nxt = 5'd0;
  end

  // Registered state and outputs; en low freezes state and zeroes pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      pre_t            <= 5'd0;
      post_t           <= 5'd0;
      bus.weight       <= W_INIT;
      bus.syn_current  <= 8'd0;
      bus.update_pulse <= 1'b0;
      bus.ltp          <= 1'b0;
      bus.ltd          <= 1'b0;
      bus.dt_out       <= 5'd0;
    end else if (bus.en) begin
      pre_t            <= pre_t_nxt;
      post_t           <= post_t_nxt;
      bus.syn_current  <= bus.pre_spike ? bus.weight : 8'd0;
      bus.update_pulse <= !bus.wload && (ltp_hit || ltd_hit);
      bus.ltp          <= !bus.wload && ltp_hit;
      bus.ltd          <= !bus.wload && ltd_hit;
      // A load overrides learning; the pairing is still consumed above.
      if (bus.wload) begin
        bus.weight <= bus.wdata;
      end else if (ltp_hit) begin
        bus.weight <= w_up;
        bus.dt_out <= pre_t;
      end else if (ltd_hit) begin
        bus.weight <= w_down;
        bus.dt_out <= post_t;
      end
    end else begin
      bus.syn_current  <= 8'd0;
      bus.update_pulse <= 1'b0;
      bus.ltp          <= 1'b0;
      bus.ltd          <= 1'b0;
    end
  end

endmodule

// File: doc/stdp_ctrl.md
Name: stdp_ctrl

Overview:
Learning controller for the two-neuron LIF pair. It timestamps presynaptic and postsynaptic spikes with saturating timers and decides potentiation or depression on each pairing. It applies a stepped STDP delta (16/8/4/2) to a saturating 8-bit synaptic weight and gates the presynaptic spike into a weighted current pulse for the postsynaptic lif. The weight is loadable for configuration.

Parameters:
W_INIT, 16, weight value after reset (0..255)
WIN, 15, STDP window in cycles; legal 1..30; pairings with dt > WIN are ignored

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
en  in  1  global enable; low freezes all state
pre_spike  in  1  spike from presynaptic lif, one-cycle pulse
post_spike  in  1  spike from postsynaptic lif, one-cycle pulse
wload  in  1  load weight from wdata this cycle
wdata  in  8  weight load value
weight  out  8  current synaptic weight
syn_current  out  8  weighted current to postsynaptic lif
update_pulse  out  1  one-cycle strobe, weight changed by learning
ltp  out  1  qualifies update_pulse: potentiation
ltd  out  1  qualifies update_pulse: depression
dt_out  out  5  spike interval of the last update

Behaviour:
- Clock and reset: one clock domain (clk); reset is asynchronous, active-low (rst_n). All outputs are registered.
- Reset values: weight=W_INIT, syn_current=0, update_pulse=ltp=ltd=0, dt_out=0; internal timers pre_t=post_t=0.
- Timers, 5 bits each. 0 means no spike since reset or pairing consumed. A spike sampled at an edge loads its timer with 1. Otherwise, if the timer is nonzero and below WIN+1, it increments on every en edge. WIN+1 means expired and holds.
- dt is the timer value before the edge, i.e. the number of edges between the two spikes.
- LTP: post_spike && !pre_spike && 1<=pre_t<=WIN.
  - weight <= min(255, weight+delta(pre_t)); dt_out<=pre_t; pre_t<=0 (pair consumed); post_t<=1.
- LTD: pre_spike && !post_spike && 1<=post_t<=WIN.
  - weight <= max(0, weight-delta(post_t)); dt_out<=post_t; post_t<=0; pre_t<=1.
- delta(dt) by dt: 1-2 -> 16; 3-4 -> 8; 5-8 -> 4; 9-30 -> 2. Arithmetic uses 9-bit intermediates, clamped to 0..255.
- Simultaneous pre_spike and post_spike: no weight change and no strobe; both timers load 1.
- A spike with its partner timer at 0 or expired only loads its own timer; no update.
- update_pulse is high for exactly the one cycle after the edge that sampled the causing spike, with exactly one of ltp/ltd high. Otherwise all three are 0. dt_out holds its value between updates.
- syn_current: at the edge sampling pre_spike, it loads the weight value from before that edge (pre-update). It returns to 0 on the next edge unless pre_spike is high again.
- wload has priority over learning in the same cycle. weight<=wdata, no strobe. Timers still update as if learning occurred, so a pairing is consumed.
- en low: spikes and wload are ignored, timers hold, weight holds, and update_pulse/ltp/ltd/syn_current are forced 0 at the next edge.
- Reset asserted mid-operation returns all state to reset values immediately. Pairings do not span a reset.

Test Plan:
- Reset with W_INIT=16, then 20 idle cycles -> weight=16, all strobes 0, syn_current=0.
- pre_spike at edge k, post_spike at edge k+2 -> at k+2 update_pulse=1, ltp=1, dt_out=2, weight 16->32; a second post at k+4 -> no update (pair consumed).
- post_spike at edge k, pre_spike at edge k+6 -> ltd=1, dt_out=6, weight 32->28; syn_current=32 for one cycle after k+6.
- pre_spike then post_spike 16 edges later (WIN=15) -> no update, weight unchanged; pre and post spike in the same cycle -> no update.
- wload wdata=250, then pre/post at dt=1 -> weight saturates at 255; wload wdata=3, then post/pre at dt=1 -> weight clamps at 0.
- Drop en for 5 cycles between pre and post (post 2 enabled edges after pre) -> dt_out=2; assert rst_n=0 mid-window -> weight=W_INIT immediately, and a following post produces no update.
